// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing and frame size.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_DATA    = 3'd3,
    ST_PARITY  = 3'd4,
    ST_STOP    = 3'd5,
    ST_ACK     = 3'd6
  } ps2_tx_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int unsigned INHIBIT_CYC_DEF  = 12000;
  localparam int unsigned START_TO_CYC_DEF = 1500000;
  localparam int unsigned BIT_TO_CYC_DEF   = 20000;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// PS/2 line synchronizer with ps2 clock falling-edge strobe.
// PS2_TX_GLITCH_FILTER_EN adds a 4-sample stability filter on the clock line.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_level,
  output logic data_level,
  output logic clk_fall_c
);

  logic [1:0] clk_s;
  logic [1:0] data_s;
  logic       clk_prev;

  // Idle bus level is high, so the flops reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s  <= 2'b11;
      data_s <= 2'b11;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      data_s <= {data_s[0], ps2_data};
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       clk_filt;
  logic [1:0] stab_cnt;

  // Output follows the synced clock only after 4 consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      stab_cnt <= 2'd0;
    end else if (clk_s[1] == clk_filt) begin
      stab_cnt <= 2'd0;
    end else if (stab_cnt == 2'd3) begin
      clk_filt <= clk_s[1];
      stab_cnt <= 2'd0;
    end else begin
      stab_cnt <= stab_cnt + 2'd1;
    end
  end

  assign clk_level = clk_filt;
`else
  assign clk_level = clk_s[1];
`endif

  assign data_level = data_s[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev <= 1'b1;
    else        clk_prev <= clk_level;
  end

  assign clk_fall_c = clk_prev & ~clk_level;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter driving the open-collector lines via pull-low enables.
// Optional clock glitch filter in ps2_sync: PS2_TX_GLITCH_FILTER_EN.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC  = INHIBIT_CYC_DEF,
  parameter int unsigned START_TO_CYC = START_TO_CYC_DEF,
  parameter int unsigned BIT_TO_CYC   = BIT_TO_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic [7:0] data_i,
  input  logic       send_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned CNT_W   = $clog2(max3(INHIBIT_CYC, START_TO_CYC, BIT_TO_CYC));
  localparam int unsigned SHIFT_W = FRAME_BITS - 2;

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TO_CYC - 1);

  ps2_tx_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic               armed_q, armed_d;
  logic               clk_oe_d, data_oe_d, busy_d, done_d, err_d;

  logic clk_level, data_level, clk_fall;

  ps2_sync u_sync (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .ps2_clk    (ps2_clk_i),
    .ps2_data   (ps2_data_i),
    .clk_level  (clk_level),
    .data_level (data_level),
    .clk_fall_c (clk_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      armed_q       <= 1'b0;
      ps2_clk_oe_o  <= 1'b0;
      ps2_data_oe_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      armed_q       <= armed_d;
      ps2_clk_oe_o  <= clk_oe_d;
      ps2_data_oe_o <= data_oe_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      err_o         <= err_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    armed_d   = armed_q;
    clk_oe_d  = 1'b0;
    data_oe_d = ps2_data_oe_o;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        armed_d = 1'b0;
        if (send_i && !busy_o) begin
          shreg_d   = {~^data_i, data_i};
          bit_d     = '0;
          state_d   = ST_INHIBIT;
          clk_oe_d  = 1'b1;
          data_oe_d = (INH_LAST == '0);
        end
      end

      // The host's own clock pull-down aliases as an edge here; ignored.
      ST_INHIBIT: begin
        armed_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          state_d   = ST_REQ;
          cnt_d     = '0;
          data_oe_d = 1'b1;
        end else begin
          clk_oe_d  = 1'b1;
          data_oe_d = (cnt_d == INH_LAST);
        end
      end

      // Edges count only once the released clock has been seen high.
      ST_REQ: begin
        armed_d = armed_q | clk_level;
        if (clk_fall && armed_q) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[SHIFT_W-1:1]};
          bit_d     = '0;
          cnt_d     = '0;
          state_d   = ST_DATA;
        end else if (cnt_q == START_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (clk_fall) begin
          cnt_d     = '0;
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[SHIFT_W-1:1]};
          if (bit_q == 3'd7) state_d = ST_PARITY;
          else               bit_d   = bit_q + 3'd1;
        end
      end

      ST_PARITY: begin
        if (clk_fall) begin
          cnt_d     = '0;
          data_oe_d = 1'b0;
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_level) begin
            state_d = ST_ACK;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_ACK: begin
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Shared per-bit watchdog; a completed handshake wins over expiry.
    if ((state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP ||
         state_q == ST_ACK) && !clk_fall && !done_d && cnt_q == BIT_LAST) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    if (state_d == ST_IDLE) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE) | done_d | err_d;
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: vector table, random bytes against a frame model, and reset/ignore corner cases.
module tb_ps2_tx;

  localparam int INH      = 20;
  localparam int START_TO = 200;
  localparam int BIT_TO   = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       clk_oe, data_oe, busy, done, err;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYC  (INH),
    .START_TO_CYC (START_TO),
    .BIT_TO_CYC   (BIT_TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ps2_clk_i     (ps2_clk_line),
    .ps2_data_i    (ps2_data_line),
    .data_i        (data),
    .send_i        (send),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_tot = 0, err_tot = 0, both_tot = 0, starts = 0;
  int pulse_bad = 0, post_bad = 0;
  int rel_cyc = 0, err_cyc = 0, last_fall = 0;
  logic prev_clk_oe = 1'b0;
  logic pulse_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (prev_clk_oe && !clk_oe) rel_cyc = cyc;
    if (!prev_clk_oe && clk_oe) starts++;
    prev_clk_oe = clk_oe;
    if (done) done_tot++;
    if (err) begin
      err_tot++;
      err_cyc = cyc;
    end
    if (done && err) both_tot++;
    if ((done || err) && (!busy || clk_oe || data_oe)) pulse_bad++;
    if (pulse_prev && busy) post_bad++;
    pulse_prev = done | err;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Line values after each device falling edge: d0..d7, odd parity, released stop.
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    logic [9:0] r;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[i];
      ones += int'(d[i]);
    end
    r[8] = ((ones % 2) == 0);
    r[9] = 1'b1;
    return r;
  endfunction

  // Device: 40-cycle clock, samples data while clock is low, acks before the 11th edge.
  task automatic run_device(input int n_edges, input bit ack, output logic [10:0] seen);
    seen = '1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < n_edges; i++) begin
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (15) @(negedge clk);
      seen[i] = ps2_data_line;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      if (i == 9 && ack) dev_data_low = 1'b1;
      repeat (10) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d, input int n_edges, input bit ack,
                      input bit poke, input bit exp_done);
    int k, first, d0, e0, s0, wait_c;
    logic [10:0] seen;
    logic [9:0]  exp_bits, mask;
    d0 = done_tot;
    e0 = err_tot;
    s0 = starts;
    @(negedge clk);
    data = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    data = 8'h00;
    check("busy_after_accept", int'(busy), 1);
    k = 0;
    first = -1;
    while (clk_oe && k < 1000) begin
      if (data_oe && first < 0) first = k;
      if (poke && k == 5) begin
        send = 1'b1;
        data = 8'hAA;
      end
      if (poke && k == 6) send = 1'b0;
      k++;
      @(negedge clk);
    end
    send = 1'b0;
    check("inhibit_len", k, INH);
    check("start_bit_cycle", first, INH - 1);
    check("start_bit_held", int'(data_oe), 1);
    run_device(n_edges, ack, seen);
    wait_c = 0;
    while ((done_tot + err_tot) == (d0 + e0) && wait_c < 400) begin
      @(negedge clk);
      wait_c++;
    end
    if (wait_c >= 400) check("pulse_wait_timeout", wait_c, 0);
    repeat (30) @(negedge clk);
    exp_bits = model_bits(d);
    mask = '0;
    for (int i = 0; i < 10; i++) if (i < n_edges) mask[i] = 1'b1;
    if (n_edges > 0) check("frame_bits", int'(seen[9:0] & mask), int'(exp_bits & mask));
    check("done_count", done_tot - d0, int'(exp_done));
    check("err_count", err_tot - e0, int'(!exp_done));
    check("one_accept", starts - s0, 1);
    check("idle_after", int'({busy, clk_oe, data_oe}), 0);
    if (n_edges == 0) check("start_timeout", err_cyc - rel_cyc, START_TO);
    else if (n_edges < 11) check_range("bit_timeout", err_cyc - last_fall, BIT_TO, BIT_TO + 10);
  endtask

  typedef struct {
    logic [7:0] data;
    int         edges;
    bit         ack;
    bit         poke;
    bit         exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] seen;
    logic [7:0]  rd;
    bit          rack;
    int          w;

    vecs[0] = '{8'hED, 11, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 11, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 0,  1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 5,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 11, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 11, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({clk_oe, data_oe, busy, done, err}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", int'({clk_oe, data_oe, busy, done, err}), 0);

    for (int v = 0; v < 6; v++)
      xfer(vecs[v].data, vecs[v].edges, vecs[v].ack, vecs[v].poke, vecs[v].exp_done);

    for (int r = 0; r < 8; r++) begin
      rd   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      xfer(rd, 11, rack, 1'b0, rack);
    end

    // Reset in the middle of the data bits, then a clean frame.
    @(negedge clk);
    data = 8'h96;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    w = 0;
    while (clk_oe && w < 100) begin
      @(negedge clk);
      w++;
    end
    run_device(4, 1'b0, seen);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_data_oe", int'(data_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_outputs", int'({clk_oe, data_oe, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    xfer(8'h96, 11, 1'b1, 1'b0, 1'b1);

    check("done_err_together", both_tot, 0);
    check("pulse_state", pulse_bad, 0);
    check("busy_after_pulse", post_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
